// File: rtl/io_input_port.sv
// io_input_port: byte FIFO from an external peripheral feeding a processor through a 3-phase req/ack handshake.
//   g_clk      in   clock, all state updates on the rising edge
//   g_clr      in   asynchronous active-low reset
//   ext_data   in   [7:0] byte from the peripheral
//   ext_valid  in   ext_data holds a byte to transfer
//   ext_ready  out  FIFO can accept a byte this cycle
//   bus_in     out  [7:0] byte offered to the processor
//   hs_in      out  handshake request to the processor
//   hs_out     in   handshake acknowledge from the processor
//   fifo_count out  [AW:0] current FIFO occupancy
//   int_req    out  data-available request (registered, tracks fifo_count != 0)
module io_input_port #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic [7:0]    ext_data,
    input  logic          ext_valid,
    output logic          ext_ready,
    output logic [7:0]    bus_in,
    output logic          hs_in,
    input  logic          hs_out,
    output logic [AW:0]   fifo_count,
    output logic          int_req
);
    typedef enum logic [1:0] {IDLE, OFFER, RELEASE} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t        r_state, w_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count, w_count_next;
    logic [7:0]    r_bus;
    logic          r_int;
    logic          w_push, w_pop, w_load;

    assign ext_ready    = r_count != FULL;
    assign w_push       = ext_valid && ext_ready;
    assign w_count_next = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    assign bus_in       = r_bus;
    assign hs_in        = r_state == OFFER;
    assign fifo_count   = r_count;
    assign int_req      = r_int;

    // The head is popped when the processor acknowledges, not when it is offered,
    // so a reset mid-offer discards the byte together with the rest of the queue.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                w_load = (r_count != '0) && !hs_out;
                w_next = w_load ? OFFER : IDLE;
            end
            OFFER: begin
                w_pop  = hs_out;
                w_next = hs_out ? RELEASE : OFFER;
            end
            RELEASE: w_next = hs_out ? RELEASE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_bus   <= 8'h00;
            r_int   <= 1'b0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            if (w_load) r_bus <= r_mem[r_rp];
            r_count <= w_count_next;
            r_int   <= w_count_next != '0;
        end
    end

    // Storage is deliberately unreset; occupancy alone says which entries are live.
    always_ff @(posedge g_clk) begin
        if (w_push) r_mem[r_wp] <= ext_data;
    end
endmodule

// File: tb/tb_io_input_port.sv
// tb_io_input_port: directed checks of io_input_port against a queue-based behavioural model.
module tb_io_input_port;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          g_clk = 1'b0;
    logic          g_clr = 1'b1;
    logic [7:0]    ext_data = 8'h00;
    logic          ext_valid = 1'b0;
    logic          ext_ready;
    logic [7:0]    bus_in;
    logic          hs_in;
    logic          hs_out = 1'b0;
    logic [AW:0]   fifo_count;
    logic          int_req;

    io_input_port #(.DEPTH(DEPTH), .AW(AW)) dut (
        .g_clk(g_clk), .g_clr(g_clr), .ext_data(ext_data), .ext_valid(ext_valid),
        .ext_ready(ext_ready), .bus_in(bus_in), .hs_in(hs_in), .hs_out(hs_out),
        .fifo_count(fifo_count), .int_req(int_req)
    );

    always #5 g_clk = ~g_clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: the queued bytes, which transfer phase the processor is in
    // (0 waiting for data, 1 byte offered, 2 waiting for ack to drop), the offered byte.
    logic [7:0] q[$];
    int         ph = 0;
    logic [7:0] m_bus = 8'h00;
    logic       m_int = 1'b0;

    logic [7:0] dut_rx[$];
    bit         auto_ack = 0;
    int         cyc = 0;
    int         last_rise = -1;
    logic       prev_hs = 1'b0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic model_step();
        int   sz;
        logic push;
        sz   = q.size();
        push = ext_valid && (sz != DEPTH);
        if (ph == 0) begin
            if (sz != 0 && !hs_out) begin
                m_bus = q[0];
                ph    = 1;
            end
        end else if (ph == 1) begin
            if (hs_out) begin
                void'(q.pop_front());
                ph = 2;
            end
        end else if (!hs_out) begin
            ph = 0;
        end
        if (push) q.push_back(ext_data);
        m_int = q.size() != 0;
    endtask

    // One clock: log accepted bytes, advance the model, compare every output at the falling edge.
    task automatic tick();
        if (hs_in && hs_out) dut_rx.push_back(bus_in);
        @(posedge g_clk);
        if (g_clr) model_step();
        @(negedge g_clk);
        cyc++;
        chk("ext_ready", {31'd0, ext_ready}, {31'd0, q.size() != DEPTH});
        chk("fifo_count", {29'd0, fifo_count}, q.size());
        chk("hs_in", {31'd0, hs_in}, {31'd0, ph == 1});
        chk("bus_in", {24'd0, bus_in}, {24'd0, m_bus});
        chk("int_req", {31'd0, int_req}, {31'd0, m_int});
        if (hs_in && !prev_hs) begin
            if (last_rise >= 0) chk("period_ge_3", {31'd0, (cyc - last_rise) >= 3}, 32'd1);
            last_rise = cyc;
        end
        prev_hs = hs_in;
        if (auto_ack) hs_out = hs_in;
    endtask

    task automatic do_reset();
        #2;
        g_clr = 1'b0;
        #1;
        chk("rst_hs_in", {31'd0, hs_in}, 32'd0);
        chk("rst_bus_in", {24'd0, bus_in}, 32'h00);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_int_req", {31'd0, int_req}, 32'd0);
        chk("rst_ext_ready", {31'd0, ext_ready}, 32'd1);
        q.delete();
        ph = 0; m_bus = 8'h00; m_int = 1'b0;
        ext_valid = 1'b0; hs_out = 1'b0; auto_ack = 0;
        last_rise = -1; prev_hs = 1'b0;
        dut_rx.delete();
        tick();
        tick();
        g_clr = 1'b1;
    endtask

    task automatic drain();
        int k;
        auto_ack = 1;
        for (k = 0; k < 200 && !(fifo_count == 0 && !hs_in && !hs_out); k++) tick();
        chk("drain_timeout", {31'd0, k < 200}, 32'd1);
        tick();
        auto_ack = 0;
    endtask

    task automatic chk_rx(string nm, logic [7:0] first, int n);
        chk({nm, "_len"}, dut_rx.size(), n);
        for (int i = 0; i < n && i < dut_rx.size(); i++)
            chk(nm, {24'd0, dut_rx[i]}, {24'd0, first + 8'(i)});
    endtask

    initial begin
        // Single byte, ack two cycles after offer
        do_reset();
        ext_valid = 1'b1; ext_data = 8'hA5;
        tick();
        ext_valid = 1'b0;
        chk("s1_count", {29'd0, fifo_count}, 32'd1);
        chk("s1_hs_pre", {31'd0, hs_in}, 32'd0);
        chk("s1_int", {31'd0, int_req}, 32'd1);
        tick();
        chk("s1_hs_rise", {31'd0, hs_in}, 32'd1);
        chk("s1_bus", {24'd0, bus_in}, 32'hA5);
        tick();
        chk("s1_hs_hold", {31'd0, hs_in}, 32'd1);
        hs_out = 1'b1;
        tick();
        chk("s1_hs_fall", {31'd0, hs_in}, 32'd0);
        chk("s1_bus_keep", {24'd0, bus_in}, 32'hA5);
        chk("s1_count0", {29'd0, fifo_count}, 32'd0);
        chk("s1_int0", {31'd0, int_req}, 32'd0);
        hs_out = 1'b0;
        tick();
        tick();
        chk_rx("s1_rx", 8'hA5, 1);

        // Fill to full with hs_out held low; fifth byte waits for the first pop
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            ext_valid = 1'b1; ext_data = 8'(i);
            tick();
        end
        ext_data = 8'h05;
        tick();
        tick();
        chk("s2_full_count", {29'd0, fifo_count}, 32'd4);
        chk("s2_full_ready", {31'd0, ext_ready}, 32'd0);
        chk("s2_bus", {24'd0, bus_in}, 32'h01);
        chk("s2_hs", {31'd0, hs_in}, 32'd1);
        hs_out = 1'b1;
        tick();
        chk("s2_pop_count", {29'd0, fifo_count}, 32'd3);
        chk("s2_pop_ready", {31'd0, ext_ready}, 32'd1);
        hs_out = 1'b0;
        tick();
        ext_valid = 1'b0;
        chk("s2_refill", {29'd0, fifo_count}, 32'd4);
        drain();
        chk_rx("s2_rx", 8'h01, 5);

        // Continuous stream of ten bytes with an automatic processor
        do_reset();
        auto_ack = 1;
        for (int i = 0, g = 0; i < 10 && g < 500; g++) begin
            logic acc;
            ext_valid = 1'b1; ext_data = 8'h10 + 8'(i);
            acc = ext_ready;
            tick();
            if (acc) i++;
        end
        ext_valid = 1'b0;
        drain();
        chk_rx("s3_rx", 8'h10, 10);

        // Push and pop on the same edge at count 2
        do_reset();
        ext_valid = 1'b1; ext_data = 8'h21;
        tick();
        ext_data = 8'h22;
        tick();
        chk("s4_count2", {29'd0, fifo_count}, 32'd2);
        chk("s4_bus21", {24'd0, bus_in}, 32'h21);
        hs_out = 1'b1; ext_data = 8'h23;
        tick();
        chk("s4_count_same", {29'd0, fifo_count}, 32'd2);
        ext_valid = 1'b0; hs_out = 1'b0;
        tick();
        tick();
        chk("s4_next_hs", {31'd0, hs_in}, 32'd1);
        chk("s4_next_bus", {24'd0, bus_in}, 32'h22);
        drain();
        chk_rx("s4_rx", 8'h21, 3);

        // Reset during an offer with three bytes queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ext_valid = 1'b1; ext_data = 8'h31 + 8'(i);
            tick();
        end
        ext_valid = 1'b0;
        chk("s5_hs", {31'd0, hs_in}, 32'd1);
        chk("s5_count3", {29'd0, fifo_count}, 32'd3);
        do_reset();
        repeat (4) tick();
        chk("s5_no_offer", {31'd0, hs_in}, 32'd0);
        chk("s5_empty", {29'd0, fifo_count}, 32'd0);

        // hs_out stuck high: wait in release, then wait in idle
        do_reset();
        ext_valid = 1'b1; ext_data = 8'h41;
        tick();
        ext_data = 8'h42;
        tick();
        ext_valid = 1'b0;
        hs_out = 1'b1;
        tick();
        repeat (3) begin
            tick();
            chk("s6_rel_hs", {31'd0, hs_in}, 32'd0);
            chk("s6_rel_count", {29'd0, fifo_count}, 32'd1);
        end
        hs_out = 1'b0;
        tick();
        hs_out = 1'b1;
        repeat (3) begin
            tick();
            chk("s6_idle_hs", {31'd0, hs_in}, 32'd0);
        end
        hs_out = 1'b0;
        tick();
        chk("s6_offer_hs", {31'd0, hs_in}, 32'd1);
        chk("s6_offer_bus", {24'd0, bus_in}, 32'h42);
        drain();
        chk_rx("s6_rx", 8'h41, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
